// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA pixel interface.
// It recovers the frame and line position from VS/BLANK, checks line and
// frame timing, and decimates 2:1 in each axis into frame-buffer write
// strobes (x_out, y_out, data_out, wr_en).
// Optional macro CAPTURE_HAVG_EN: averages each horizontal pixel pair
// instead of keeping only the even pixel.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       vid_hs_n,
  input  logic       vid_vs_n,
  input  logic       vid_blank_n,
  input  logic [7:0] vid_data,
  output logic [9:0] x_out,
  output logic [8:0] y_out,
  output logic [7:0] data_out,
  output logic       wr_en,
  output logic       frame_start,
  output logic       frame_done,
  output logic       err_line,
  output logic       err_frame,
  output logic       locked
);

  typedef enum logic [1:0] {IDLE, VSYNC, ACTIVE, WAIT_VS} state_t;

  localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
  localparam logic [9:0] PX_MAX  = 10'd1023;
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  // Input sample registers and their one-sample history
  logic       hs_r;
  logic       vs_r;
  logic       blank_r;
  logic [7:0] data_r;
  logic       prev_vs_r;
  logic       prev_blank_r;

  state_t     state_r;
  logic [9:0] px_r;
  logic [9:0] ln_r;
  logic       bad_r;
  logic [3:0] good_r;
`ifdef CAPTURE_HAVG_EN
  logic [7:0] hold_r;
  logic [8:0] avg_s;
`endif

  logic       vs_fall_s;
  logic       vs_rise_s;
  logic       blank_fall_s;
  logic [9:0] ln_after_s;
  logic       in_active_s;
  logic       last_line_s;
  logic       line_err_s;
  logic       frame_err_s;
  logic       done_s;
  logic       write_s;
  logic [3:0] good_next_s;

  // Register the video pins only on pixel-enable cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r         <= 1'b1;
      vs_r         <= 1'b1;
      blank_r      <= 1'b0;
      data_r       <= 8'd0;
      prev_vs_r    <= 1'b1;
      prev_blank_r <= 1'b0;
    end else if (pix_en) begin
      hs_r         <= vid_hs_n;
      vs_r         <= vid_vs_n;
      blank_r      <= vid_blank_n;
      data_r       <= vid_data;
      prev_vs_r    <= vs_r;
      prev_blank_r <= blank_r;
    end
  end

  // Edge detection, line/frame checks and decimation decision for this sample
  always_comb begin
    vs_fall_s    = prev_vs_r & ~vs_r;
    vs_rise_s    = ~prev_vs_r & vs_r;
    blank_fall_s = prev_blank_r & ~blank_r;
    in_active_s  = pix_en && (state_r == ACTIVE);
    if (blank_fall_s) begin
      ln_after_s = ln_r + 10'd1;
    end else begin
      ln_after_s = ln_r;
    end
    // The line is closed before the frame check, so a vsync coincident with
    // the last line's blank edge still completes the frame.
    last_line_s = blank_fall_s && (ln_after_s == V_LIM);
    line_err_s  = in_active_s && blank_fall_s && (px_r != H_LIM);
    done_s      = in_active_s && last_line_s;
    frame_err_s = in_active_s && vs_fall_s && !last_line_s;
`ifdef CAPTURE_HAVG_EN
    avg_s   = {1'b0, hold_r} + {1'b0, data_r} + 9'd1;
    write_s = in_active_s && blank_r && px_r[0] && !ln_r[0] && (px_r < H_LIM);
`else
    write_s = in_active_s && blank_r && !px_r[0] && !ln_r[0] && (px_r < H_LIM);
`endif
    if (good_r == LOCK_N) begin
      good_next_s = good_r;
    end else begin
      good_next_s = good_r + 4'd1;
    end
  end

  // Capture FSM with position counters and registered write/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      px_r        <= 10'd0;
      ln_r        <= 10'd0;
      bad_r       <= 1'b0;
      x_out       <= 10'd0;
      y_out       <= 9'd0;
      data_out    <= 8'd0;
      wr_en       <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
`ifdef CAPTURE_HAVG_EN
      hold_r      <= 8'd0;
`endif
    end else begin
      wr_en       <= write_s;
      frame_start <= 1'b0;
      frame_done  <= done_s;
      err_line    <= line_err_s;
      err_frame   <= frame_err_s;
      if (write_s) begin
        x_out <= {1'b0, px_r[9:1]};
        y_out <= ln_r[9:1];
`ifdef CAPTURE_HAVG_EN
        data_out <= avg_s[8:1];
`else
        data_out <= data_r;
`endif
      end
      if (pix_en) begin
        case (state_r)
          IDLE: begin
            if (vs_fall_s) state_r <= VSYNC;
          end
          VSYNC: begin
            if (vs_rise_s) begin
              state_r     <= ACTIVE;
              px_r        <= 10'd0;
              ln_r        <= 10'd0;
              bad_r       <= 1'b0;
              frame_start <= 1'b1;
            end
          end
          ACTIVE: begin
            if (blank_r) begin
`ifdef CAPTURE_HAVG_EN
              if (!px_r[0]) hold_r <= data_r;
`endif
              if (px_r != PX_MAX) px_r <= px_r + 10'd1;
            end
            if (blank_fall_s) begin
              px_r <= 10'd0;
              ln_r <= ln_after_s;
            end
            if (line_err_s || frame_err_s) bad_r <= 1'b1;
            if (last_line_s) begin
              state_r <= vs_fall_s ? VSYNC : WAIT_VS;
            end else if (vs_fall_s) begin
              state_r <= VSYNC;
            end
          end
          WAIT_VS: begin
            if (vs_fall_s) state_r <= VSYNC;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Lock tracking: count clean frames, clear on any timing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_r <= 4'd0;
      locked <= 1'b0;
    end else if (line_err_s || frame_err_s) begin
      good_r <= 4'd0;
      locked <= 1'b0;
    end else if (done_s && !bad_r) begin
      good_r <= good_next_s;
      locked <= (good_next_s == LOCK_N);
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a scaled 16x8 active raster
// (28 samples per line, 13 lines per frame) so each frame is short.
module tb_vga_capture;

  localparam int H = 16;
  localparam int V = 8;
  localparam int HTOT = 28;
  localparam int WPF = (H / 2) * (V / 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       vid_hs_n = 1'b1;
  logic       vid_vs_n = 1'b1;
  logic       vid_blank_n = 1'b0;
  logic [7:0] vid_data = 8'd0;
  logic [9:0] x_out;
  logic [8:0] y_out;
  logic [7:0] data_out;
  logic       wr_en, frame_start, frame_done, err_line, err_frame, locked;

  int tests = 0;
  int fails = 0;
  int toggle = 0;

  int n_wr, n_fs, n_fd, n_el, n_ef, n_viol, max_x;
  logic [26:0] wq[$];
  logic        lock_q[$];
  logic        last_pix = 1'b0;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vid_hs_n(vid_hs_n),
    .vid_vs_n(vid_vs_n), .vid_blank_n(vid_blank_n), .vid_data(vid_data),
    .x_out(x_out), .y_out(y_out), .data_out(data_out), .wr_en(wr_en),
    .frame_start(frame_start), .frame_done(frame_done), .err_line(err_line),
    .err_frame(err_frame), .locked(locked)
  );

  always #5 clk = ~clk;

  // pix_en of the cycle that ends at each rising edge
  always @(posedge clk) last_pix = pix_en;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      wq.push_back({y_out, x_out, data_out});
      if (int'(x_out) > max_x) max_x = int'(x_out);
      if (!last_pix) n_viol++;
    end
    if (frame_start) n_fs++;
    if (frame_done) begin
      n_fd++;
      lock_q.push_back(locked);
    end
    if (err_line) n_el++;
    if (err_frame) n_ef++;
  end

  function automatic logic [7:0] pat(input int s);
`ifdef CAPTURE_HAVG_EN
    if (s == 0) return 8'd10;
    if (s == 1) return 8'd13;
    if (s == 2 || s == 3) return 8'd255;
`endif
    return 8'(s);
  endfunction

  function automatic logic [7:0] exp_data(input int x);
`ifdef CAPTURE_HAVG_EN
    int a;
    a = (int'(pat(2 * x)) + int'(pat(2 * x + 1)) + 1) / 2;
    return 8'(a);
`else
    return pat(2 * x);
`endif
  endfunction

  function automatic int seq_errors();
    int e = 0;
    if (wq.size() != WPF) return 9999;
    for (int i = 0; i < WPF; i++) begin
      if (wq[i] !== {9'(i / (H / 2)), 10'(i % (H / 2)), exp_data(i % (H / 2))}) e++;
    end
    return e;
  endfunction

  task automatic clr();
    n_wr = 0; n_fs = 0; n_fd = 0; n_el = 0; n_ef = 0; n_viol = 0; max_x = 0;
    wq.delete();
    lock_q.delete();
  endtask

  task automatic put(input logic hs, input logic vs, input logic bl, input logic [7:0] d);
    @(posedge clk); #1;
    pix_en = 1'b1; vid_hs_n = hs; vid_vs_n = vs; vid_blank_n = bl; vid_data = d;
    if (toggle != 0) begin
      @(posedge clk); #1;
      pix_en = 1'b0; vid_blank_n = ~bl; vid_vs_n = ~vs; vid_data = 8'hEE;
    end
  endtask

  task automatic send_line(input logic vs, input int len);
    for (int s = 0; s < HTOT; s++)
      put(!(s >= 22 && s < 25), vs, (s < len), (s < len) ? pat(s) : 8'd0);
  endtask

  task automatic send_frame(input int short_ln, input int len_ln, input int abort_ln);
    repeat (2) send_line(1'b0, 0);
    repeat (2) send_line(1'b1, 0);
    for (int ln = 0; ln < V; ln++) begin
      if (ln == abort_ln) return;
      send_line(1'b1, (ln == short_ln) ? len_ln : H);
    end
    send_line(1'b1, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({x_out, y_out, data_out, wr_en, frame_start, frame_done, err_line, err_frame, locked} !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", {x_out, y_out, data_out, wr_en, frame_start, frame_done, err_line, err_frame, locked});
    end
    rst_n = 1'b1;
    pix_en = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_nominal();
    for (int f = 0; f < 3; f++) begin
      clr();
      send_frame(-1, 0, -1);
      tests++;
      if (n_wr !== WPF) begin fails++; $display("FAIL nom_writes f%0d: got %0d want %0d", f, n_wr, WPF); end
      tests++;
      if (n_fs !== 1 || n_fd !== 1) begin fails++; $display("FAIL nom_pulses f%0d: start %0d done %0d want 1 1", f, n_fs, n_fd); end
      tests++;
      if (lock_q.size() !== 1 || lock_q[0] !== (f >= 1)) begin
        fails++; $display("FAIL nom_lock f%0d: got %b want %b", f, (lock_q.size() > 0) ? lock_q[0] : 1'bx, (f >= 1));
      end
      if (f == 0) begin
        tests++;
        if (seq_errors() !== 0) begin fails++; $display("FAIL nom_sequence: %0d bad entries want 0", seq_errors()); end
        tests++;
`ifdef CAPTURE_HAVG_EN
        if (wq[3 * 8 + 5] !== {9'd3, 10'd5, 8'd11}) begin fails++; $display("FAIL nom_x5y3: got %h want %h", wq[29], {9'd3, 10'd5, 8'd11}); end
        tests++;
        if (wq[0][7:0] !== 8'd12 || wq[1][7:0] !== 8'd255) begin
          fails++; $display("FAIL havg_pairs: got %0d %0d want 12 255", wq[0][7:0], wq[1][7:0]);
        end
`else
        if (wq[3 * 8 + 5] !== {9'd3, 10'd5, 8'd10}) begin fails++; $display("FAIL nom_x5y3: got %h want %h", wq[29], {9'd3, 10'd5, 8'd10}); end
`endif
      end
    end
  endtask

  task automatic test_short_line();
    clr();
    send_frame(4, 14, -1);
    tests++;
    if (n_el !== 1) begin fails++; $display("FAIL short_errline: got %0d want 1", n_el); end
    tests++;
    if (n_wr !== WPF - 1) begin fails++; $display("FAIL short_writes: got %0d want %0d", n_wr, WPF - 1); end
    tests++;
    if (locked !== 1'b0) begin fails++; $display("FAIL short_lockdrop: got %b want 0", locked); end
    for (int f = 0; f < 2; f++) begin
      clr();
      send_frame(-1, 0, -1);
      tests++;
      if (lock_q.size() !== 1 || lock_q[0] !== (f == 1)) begin
        fails++; $display("FAIL short_relock f%0d: got %b want %b", f, (lock_q.size() > 0) ? lock_q[0] : 1'bx, (f == 1));
      end
    end
  endtask

  task automatic test_long_line();
    clr();
    send_frame(2, 20, -1);
    tests++;
    if (n_el !== 1) begin fails++; $display("FAIL long_errline: got %0d want 1", n_el); end
    tests++;
    if (max_x !== H / 2 - 1) begin fails++; $display("FAIL long_xlimit: max x %0d want %0d", max_x, H / 2 - 1); end
    tests++;
    if (n_wr !== WPF) begin fails++; $display("FAIL long_writes: got %0d want %0d", n_wr, WPF); end
  endtask

  task automatic test_abort();
    clr();
    send_frame(-1, 0, 4);
    tests++;
    if (n_fd !== 0 || n_wr !== 16) begin fails++; $display("FAIL abort_partial: done %0d writes %0d want 0 16", n_fd, n_wr); end
    clr();
    send_frame(-1, 0, -1);
    tests++;
    if (n_ef !== 1) begin fails++; $display("FAIL abort_errframe: got %0d want 1", n_ef); end
    tests++;
    if (n_fd !== 1 || n_wr !== WPF) begin fails++; $display("FAIL abort_next: done %0d writes %0d want 1 %0d", n_fd, n_wr, WPF); end
    tests++;
    if (wq.size() == 0 || wq[0] !== {9'd0, 10'd0, exp_data(0)}) begin
      fails++; $display("FAIL abort_first_write: got %h want %h", (wq.size() > 0) ? wq[0] : 27'h0, {9'd0, 10'd0, exp_data(0)});
    end
  endtask

  task automatic test_pix_toggle();
    toggle = 1;
    clr();
    send_frame(-1, 0, -1);
    toggle = 0;
    tests++;
    if (seq_errors() !== 0) begin fails++; $display("FAIL toggle_sequence: %0d bad entries want 0", seq_errors()); end
    tests++;
    if (n_viol !== 0) begin fails++; $display("FAIL toggle_wr_on_idle: got %0d want 0", n_viol); end
  endtask

  task automatic test_reset_mid();
    repeat (2) send_line(1'b0, 0);
    repeat (2) send_line(1'b1, 0);
    for (int ln = 0; ln < 4; ln++) send_line(1'b1, H);
    for (int s = 0; s <= 6; s++) put(1'b1, 1'b1, 1'b1, pat(s));
    tests++;
    if (wr_en !== 1'b1) begin fails++; $display("FAIL mid_prewrite: got %b want 1", wr_en); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({x_out, y_out, data_out, wr_en, frame_start, frame_done, err_line, err_frame, locked} !== 34'd0) begin
      fails++; $display("FAIL mid_async_reset: got %h want 0", {x_out, y_out, data_out, wr_en, frame_start, frame_done, err_line, err_frame, locked});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    clr();
    for (int s = 7; s < HTOT; s++) put(1'b1, 1'b1, (s < H), pat(s));
    for (int ln = 5; ln < V; ln++) send_line(1'b1, H);
    send_line(1'b1, 0);
    tests++;
    if (n_wr !== 0 || n_fs !== 0) begin fails++; $display("FAIL mid_no_capture: writes %0d starts %0d want 0 0", n_wr, n_fs); end
    clr();
    send_frame(-1, 0, -1);
    tests++;
    if (n_wr !== WPF || n_fs !== 1) begin fails++; $display("FAIL mid_recover: writes %0d starts %0d want %0d 1", n_wr, n_fs, WPF); end
  endtask

  initial begin
    clr();
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_abort();
    test_pix_toggle();
    test_reset_mid();
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
